// File: rtl/csr_uart_fifo.sv
// csr_uart_fifo
//   Buffered UART behind one CSR address. It replaces the simulation-only
//   character sink with real serial hardware. TX and RX bytes go through
//   small circular FIFOs. Read data is OR-merged onto the shared CSR bus,
//   so rdata is zero whenever valid is low.
//
//   Build option: define CSR_UART_RX_EN to build the receive path.
//   Without it, rx is ignored and the RX status reads as permanently empty.
//
//   Ports:
//     clk            system clock
//     rstn           synchronous active-low reset
//     read, addr     CSR read strobe and address (cycle N)
//     modify, wdata  CSR modify code and write data (cycle N+1); code 1 = write
//     rdata, valid   read data and claim (cycle N+1)
//     rx             asynchronous serial input, idle high
//     tx             serial output, idle high
//     AVOID_WARNING  tied 0
//
//   Read word: [7:0] RX head byte, [8] RX empty, [9] TX full,
//              [10] RX overflow (sticky), [11] RX framing error (sticky)
module csr_uart_fifo #(
  parameter logic [11:0] BASE_ADDR = 12'hBC0,
  parameter int unsigned BAUD_DIV  = 868,
  parameter int unsigned TX_LOG2   = 2,
  parameter int unsigned RX_LOG2   = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx,
  output logic        tx,
  output logic        AVOID_WARNING
);

  localparam int unsigned TX_DEPTH = 1 << TX_LOG2;
  localparam logic [15:0] BAUD_M1  = 16'(BAUD_DIV - 1);

  // ---------------- CSR access ----------------
  logic hit_q;
  logic wr_en;

  always_ff @(posedge clk) begin
    if (!rstn) hit_q <= 1'b0;
    else       hit_q <= read && (addr == BASE_ADDR);
  end

  assign valid = hit_q;
  assign wr_en = hit_q && (modify == 3'd1);

  // ---------------- TX FIFO ----------------
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [TX_LOG2:0] tx_wptr_q, tx_wptr_d;
  logic [TX_LOG2:0] tx_rptr_q, tx_rptr_d;
  logic             tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]       tx_head;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[TX_LOG2-1:0] == tx_rptr_q[TX_LOG2-1:0]) &&
                    (tx_wptr_q[TX_LOG2] != tx_rptr_q[TX_LOG2]);
  // Full is judged at the start of the cycle, so a same-cycle pop does not rescue the byte.
  assign tx_push  = wr_en && !tx_full;
  assign tx_head  = tx_mem_q[tx_rptr_q[TX_LOG2-1:0]];

  assign tx_wptr_d = tx_wptr_q + {{TX_LOG2{1'b0}}, tx_push};
  assign tx_rptr_d = tx_rptr_q + {{TX_LOG2{1'b0}}, tx_pop};

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q[TX_LOG2-1:0]] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
    end
  end

  // ---------------- TX FSM ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  tx_state_e   tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        tx_q;

  // The head byte is popped on entry to START, from IDLE or straight out of STOP.
  assign tx_pop = !tx_empty &&
                  ((tx_state_q == TX_IDLE) ||
                   ((tx_state_q == TX_STOP) && (tx_cnt_q == 16'd0)));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_state_q <= TX_START;
            tx_cnt_q   <= BAUD_M1;
            tx_shift_q <= tx_head;
            tx_q       <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt_q == 16'd0) begin
            tx_state_q <= TX_DATA;
            tx_cnt_q   <= BAUD_M1;
            tx_bit_q   <= 3'd0;
            tx_q       <= tx_shift_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == 16'd0) begin
            tx_cnt_q <= BAUD_M1;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= TX_STOP;
              tx_q       <= 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_q       <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == 16'd0) begin
            if (tx_pop) begin
              tx_state_q <= TX_START;
              tx_cnt_q   <= BAUD_M1;
              tx_shift_q <= tx_head;
              tx_q       <= 1'b0;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end

  assign tx            = tx_q;
  assign AVOID_WARNING = 1'b0;

  // ---------------- RX path ----------------
  logic [31:0] status;

`ifdef CSR_UART_RX_EN
  localparam int unsigned RX_DEPTH = 1 << RX_LOG2;
  localparam logic [15:0] HALF_M1  = 16'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e        rx_state_q;
  logic [15:0]      rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [RX_LOG2:0] rx_wptr_q, rx_wptr_d;
  logic [RX_LOG2:0] rx_rptr_q, rx_rptr_d;
  logic             rx_full, rx_empty, rx_push, rx_pop;
  logic             rx_stop_smp, ovf_set, ferr_set;
  logic             ovf_q, ferr_q;
  logic [7:0]       rx_head;
  logic             unused_rx_bits;

  assign rx_empty    = (rx_wptr_q == rx_rptr_q);
  assign rx_full     = (rx_wptr_q[RX_LOG2-1:0] == rx_rptr_q[RX_LOG2-1:0]) &&
                       (rx_wptr_q[RX_LOG2] != rx_rptr_q[RX_LOG2]);
  assign rx_head     = rx_mem_q[rx_rptr_q[RX_LOG2-1:0]];
  assign rx_stop_smp = (rx_state_q == RX_STOP) && (rx_cnt_q == 16'd0);
  assign rx_push     = rx_stop_smp && rx_s2_q && !rx_full;
  assign ovf_set     = rx_stop_smp && rx_s2_q && rx_full;
  assign ferr_set    = rx_stop_smp && !rx_s2_q;
  assign rx_pop      = hit_q && !rx_empty;

  assign rx_wptr_d = rx_wptr_q + {{RX_LOG2{1'b0}}, rx_push};
  assign rx_rptr_d = rx_rptr_q + {{RX_LOG2{1'b0}}, rx_pop};

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q[RX_LOG2-1:0]] <= rx_shift_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      // A hit read clears the sticky bits; a new error in the same cycle wins.
      ovf_q     <= ovf_set  | (ovf_q  & ~hit_q);
      ferr_q    <= ferr_set | (ferr_q & ~hit_q);
    end
  end

  // Re-arming needs a falling edge, so after a framing error the line must
  // return high before the next frame is accepted.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= HALF_M1;
          end
        end
        RX_START: begin
          if (rx_cnt_q == 16'd0) begin
            if (rx_s2_q) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_state_q <= RX_DATA;
              rx_cnt_q   <= BAUD_M1;
              rx_bit_q   <= 3'd0;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == 16'd0) begin
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            rx_cnt_q   <= BAUD_M1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == 16'd0) rx_state_q <= RX_IDLE;
          else                   rx_cnt_q   <= rx_cnt_q - 16'd1;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign unused_rx_bits = ^{wdata[31:8]};
  assign status = {20'd0, ferr_q, ovf_q, tx_full, rx_empty,
                   (rx_empty ? 8'd0 : rx_head)};
`else
  logic unused_rx_bits;

  assign unused_rx_bits = ^{wdata[31:8], rx, RX_LOG2[0]};
  assign status = {20'd0, 1'b0, 1'b0, tx_full, 1'b1, 8'd0};
`endif

  assign rdata = hit_q ? status : 32'd0;

endmodule
